sram_axi_bridge: RTL and testbench

SRAM_AXI_BRIDGE -- requirements
Module: sram_axi_bridge

---
 rtl/sram_axi_bridge.sv | 152 +++++++++++++++
 tb/tb_sram_axi_bridge.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_axi_bridge.sv
// Multi-port SRAM-like to single-beat AXI bridge.
// Fixed-priority arbitration, per-port read credit, one write in flight.
module sram_axi_bridge #(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = 32,
    parameter int RD_DEPTH  = 2,
    parameter int ID_W      = 1
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic [NUM_PORTS-1:0]          s_req,
    input  logic [NUM_PORTS-1:0]          s_wr,
    input  logic [2*NUM_PORTS-1:0]        s_size,
    input  logic [4*NUM_PORTS-1:0]        s_wstrb,
    input  logic [ADDR_W*NUM_PORTS-1:0]   s_addr,
    input  logic [32*NUM_PORTS-1:0]       s_wdata,
    output logic [NUM_PORTS-1:0]          s_addr_ok,
    output logic [NUM_PORTS-1:0]          s_data_ok,
    output logic [31:0]                   s_rdata,
    output logic [ID_W-1:0]               arid,
    output logic [ADDR_W-1:0]             araddr,
    output logic [2:0]                    arsize,
    output logic                          arvalid,
    input  logic                          arready,
    input  logic [ID_W-1:0]               rid,
    input  logic [31:0]                   rdata,
    input  logic                          rvalid,
    output logic                          rready,
    output logic [ADDR_W-1:0]             awaddr,
    output logic [2:0]                    awsize,
    output logic                          awvalid,
    input  logic                          awready,
    output logic [31:0]                   wdata,
    output logic [3:0]                    wstrb,
    output logic                          wvalid,
    input  logic                          wready,
    input  logic                          bvalid,
    output logic                          bready
);
    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] DEPTH = CNT_W'(RD_DEPTH);

    logic [CNT_W-1:0]     cnt [NUM_PORTS];
    logic                 wr_busy;
    logic [ID_W-1:0]      wr_owner;
    logic                 ar_free;
    logic                 b_ok;
    logic                 rd_err;
    logic [NUM_PORTS-1:0] grant;
    logic [NUM_PORTS-1:0] r_hit;
    logic                 gnt_rd;
    logic                 gnt_wr;
    logic [ID_W-1:0]      gnt_id;
    logic [ADDR_W-1:0]    gnt_addr;
    logic [1:0]           gnt_size;
    logic [31:0]          gnt_wdata;
    logic [3:0]           gnt_wstrb;

    assign ar_free = !arvalid || arready;
    assign b_ok    = bvalid && wr_busy;
    assign rready  = 1'b1;
    assign bready  = 1'b1;
    assign s_rdata = rdata;

    // Later (higher-index) eligible ports override earlier ones.
    always_comb begin
        grant     = '0;
        gnt_rd    = 1'b0;
        gnt_wr    = 1'b0;
        gnt_id    = '0;
        gnt_addr  = '0;
        gnt_size  = '0;
        gnt_wdata = '0;
        gnt_wstrb = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (s_req[i] && (s_wr[i]
                    ? (cnt[i] == '0 && !wr_busy && !awvalid && !wvalid)
                    : (cnt[i] < DEPTH && !wr_busy && ar_free))) begin
                grant     = '0;
                grant[i]  = 1'b1;
                gnt_rd    = !s_wr[i];
                gnt_wr    = s_wr[i];
                gnt_id    = ID_W'(i);
                gnt_addr  = s_addr[i*ADDR_W +: ADDR_W];
                gnt_size  = s_size[i*2 +: 2];
                gnt_wdata = s_wdata[i*32 +: 32];
                gnt_wstrb = s_wstrb[i*4 +: 4];
            end
        end
    end

    always_comb begin
        r_hit     = '0;
        s_data_ok = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            r_hit[i]     = rvalid && rid == ID_W'(i) && cnt[i] != '0;
            s_data_ok[i] = resetn
                && (r_hit[i] || (b_ok && wr_owner == ID_W'(i)));
        end
        rd_err    = rvalid && r_hit == '0;
        s_addr_ok = grant & {NUM_PORTS{resetn}};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            arvalid  <= 1'b0;
            arid     <= '0;
            araddr   <= '0;
            arsize   <= '0;
            awvalid  <= 1'b0;
            awaddr   <= '0;
            awsize   <= '0;
            wvalid   <= 1'b0;
            wdata    <= '0;
            wstrb    <= '0;
            wr_busy  <= 1'b0;
            wr_owner <= '0;
            for (int i = 0; i < NUM_PORTS; i++) cnt[i] <= '0;
        end else begin
            if (arready) arvalid <= 1'b0;
            if (gnt_rd) begin
                arvalid <= 1'b1;
                arid    <= gnt_id;
                araddr  <= gnt_addr;
                arsize  <= {1'b0, gnt_size};
            end
            if (awready) awvalid <= 1'b0;
            if (wready) wvalid <= 1'b0;
            if (b_ok) wr_busy <= 1'b0;
            if (gnt_wr) begin
                awvalid  <= 1'b1;
                wvalid   <= 1'b1;
                awaddr   <= gnt_addr;
                awsize   <= {1'b0, gnt_size};
                wdata    <= gnt_wdata;
                wstrb    <= gnt_wstrb;
                wr_busy  <= 1'b1;
                wr_owner <= gnt_id;
            end
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (grant[i] && gnt_rd && !r_hit[i])
                    cnt[i] <= cnt[i] + 1'b1;
                else if (r_hit[i] && !(grant[i] && gnt_rd))
                    cnt[i] <= cnt[i] - 1'b1;
            end
        end
    end

    // An R beat for a port with nothing outstanding is a slave protocol error.
    a_r_owner: assert property (@(posedge clk) disable iff (!resetn) !rd_err);

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Directed vector table, corner-case sequences and a randomised
// AXI slave run with per-port in-order scoreboarding.
module tb_sram_axi_bridge;
    localparam int NREQ   = 10000;
    localparam int BUDGET = 80000;
    localparam logic [31:0] K = 32'h5a5a_0f0f;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [1:0]  s_req, s_wr, s_addr_ok, s_data_ok;
    logic [3:0]  s_size;
    logic [7:0]  s_wstrb;
    logic [63:0] s_addr, s_wdata;
    logic [31:0] s_rdata, araddr, rdata, awaddr, wdata;
    logic [0:0]  arid, rid;
    logic [2:0]  arsize, awsize;
    logic [3:0]  wstrb;
    logic arvalid, arready, rvalid, rready, awvalid, awready;
    logic wvalid, wready, bvalid, bready;

    sram_axi_bridge #(
        .NUM_PORTS(2), .ADDR_W(32), .RD_DEPTH(2), .ID_W(1)
    ) dut (
        .clk(clk), .resetn(resetn),
        .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_wstrb(s_wstrb),
        .s_addr(s_addr), .s_wdata(s_wdata),
        .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata),
        .arid(arid), .araddr(araddr), .arsize(arsize),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [1:0] req;
        logic [1:0] wr;
        logic [1:0] ok;
        logic       arv;
        logic [0:0] aid;
        logic       awv;
    } vec_t;
    vec_t vt[8];

    typedef struct {
        logic        wr;
        logic [31:0] data;
    } exp_t;
    exp_t        eq[2][$];
    logic [31:0] rq[2][$];

    logic [1:0]  m_act, m_wr;
    logic [31:0] m_addr[2], m_data[2];
    logic [31:0] cur_wa, cur_wd;
    logic        aw_got, w_got;
    int          issued, accepted, cyc;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        s_req = '0; s_wr = '0; s_size = 4'b1010; s_wstrb = '1;
        s_addr = '0; s_wdata = '0;
        arready = 1'b0; rid = '0; rdata = '0; rvalid = 1'b0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
    endtask

    task automatic do_reset();
        tick();
        resetn = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    task automatic set_port(input int p, input logic wr,
                            input logic [31:0] a, input logic [31:0] d);
        s_wr[p] = wr;
        s_addr[p*32 +: 32] = a;
        s_wdata[p*32 +: 32] = d;
        s_size[p*2 +: 2] = 2'd2;
        s_wstrb[p*4 +: 4] = 4'hf;
    endtask

    initial begin
        vt[0] = '{2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
        vt[1] = '{2'b01, 2'b00, 2'b01, 1'b1, 1'b0, 1'b0};
        vt[2] = '{2'b10, 2'b00, 2'b10, 1'b1, 1'b1, 1'b0};
        vt[3] = '{2'b11, 2'b00, 2'b10, 1'b1, 1'b1, 1'b0};
        vt[4] = '{2'b11, 2'b01, 2'b10, 1'b1, 1'b1, 1'b0};
        vt[5] = '{2'b11, 2'b10, 2'b10, 1'b0, 1'b0, 1'b1};
        vt[6] = '{2'b01, 2'b01, 2'b01, 1'b0, 1'b0, 1'b1};
        vt[7] = '{2'b11, 2'b11, 2'b10, 1'b0, 1'b0, 1'b1};

        // reset state, with requests and a beat present
        idle_inputs();
        s_req = 2'b11;
        rvalid = 1'b1;
        #2;
        chk("rst_arvalid", arvalid, 0);
        chk("rst_awvalid", awvalid, 0);
        chk("rst_wvalid", wvalid, 0);
        chk("rst_addr_ok", s_addr_ok, 0);
        chk("rst_data_ok", s_data_ok, 0);
        chk("rst_araddr", araddr, 0);
        chk("rready_hi", rready, 1);
        chk("bready_hi", bready, 1);
        s_req = '0;
        rvalid = 1'b0;

        for (int k = 0; k < 8; k++) begin
            do_reset();
            set_port(0, vt[k].wr[0], 32'h100, 32'h11);
            set_port(1, vt[k].wr[1], 32'h200, 32'h22);
            s_req = vt[k].req;
            #1;
            chk($sformatf("vec%0d_ok", k), s_addr_ok, vt[k].ok);
            tick();
            s_req = '0;
            #1;
            chk($sformatf("vec%0d_arv", k), arvalid, vt[k].arv);
            chk($sformatf("vec%0d_arid", k), arid, vt[k].aid);
            chk($sformatf("vec%0d_awv", k), awvalid, vt[k].awv);
            chk($sformatf("vec%0d_wv", k), wvalid, vt[k].awv);
        end

        // simultaneous reads
        do_reset();
        arready = 1'b1;
        set_port(0, 1'b0, 32'h0000_1000, 0);
        set_port(1, 1'b0, 32'h1c00_0000, 0);
        s_req = 2'b11;
        #1 chk("s35_ok_p1", s_addr_ok, 2'b10);
        tick();
        s_req = 2'b01;
        #1 chk("s35_ok_p0", s_addr_ok, 2'b01);
        chk("s35_arid1", arid, 1);
        chk("s35_araddr1", araddr, 32'h1c00_0000);
        chk("s35_arsize1", arsize, 3'd2);
        tick();
        s_req = 2'b00;
        #1 chk("s35_arid0", arid, 0);
        chk("s35_araddr0", araddr, 32'h0000_1000);
        chk("s35_arv", arvalid, 1);
        tick();
        chk("s35_arv_drop", arvalid, 0);

        // read credit stall
        do_reset();
        arready = 1'b1;
        set_port(0, 1'b0, 32'h40, 0);
        s_req = 2'b01;
        #1 chk("s36_ok1", s_addr_ok, 2'b01);
        tick();
        set_port(0, 1'b0, 32'h44, 0);
        #1 chk("s36_ok2", s_addr_ok, 2'b01);
        tick();
        set_port(0, 1'b0, 32'h48, 0);
        #1 chk("s36_stall_a", s_addr_ok, 2'b00);
        tick();
        #1 chk("s36_stall_b", s_addr_ok, 2'b00);
        rvalid = 1'b1; rid = 1'b0; rdata = 32'hdeadbeef;
        #1 chk("s36_data_ok", s_data_ok, 2'b01);
        chk("s36_rdata", s_rdata, 32'hdeadbeef);
        chk("s36_stall_c", s_addr_ok, 2'b00);
        tick();
        rvalid = 1'b0;
        #1 chk("s36_ok3", s_addr_ok, 2'b01);
        tick();
        s_req = 2'b00;
        #1 chk("s36_araddr3", araddr, 32'h48);

        // write with delayed awready, read posted meanwhile
        do_reset();
        wready = 1'b1;
        arready = 1'b1;
        set_port(1, 1'b1, 32'h80, 32'h1234_5678);
        s_req = 2'b10;
        #1 chk("s37_ok_w", s_addr_ok, 2'b10);
        tick();
        set_port(1, 1'b0, 32'h200, 0);
        #1 chk("s37_aw_c1", awvalid, 1);
        chk("s37_w_c1", wvalid, 1);
        chk("s37_awaddr", awaddr, 32'h80);
        chk("s37_awsize", awsize, 3'd2);
        chk("s37_wdata", wdata, 32'h1234_5678);
        chk("s37_wstrb", wstrb, 4'hf);
        chk("s37_rd_blk1", s_addr_ok, 2'b00);
        tick();
        chk("s37_aw_c2", awvalid, 1);
        chk("s37_w_c2", wvalid, 0);
        tick();
        chk("s37_aw_c3", awvalid, 1);
        tick();
        chk("s37_aw_c4", awvalid, 1);
        awready = 1'b1;
        tick();
        awready = 1'b0;
        #1 chk("s37_aw_c5", awvalid, 0);
        chk("s37_rd_blk2", s_addr_ok, 2'b00);
        bvalid = 1'b1;
        #1 chk("s37_b_ok", s_data_ok, 2'b10);
        chk("s37_rd_blk3", s_addr_ok, 2'b00);
        tick();
        bvalid = 1'b0;
        #1 chk("s37_rd_go", s_addr_ok, 2'b10);
        tick();
        s_req = 2'b00;
        #1 chk("s37_araddr", araddr, 32'h200);
        chk("s37_arid", arid, 1);

        // R and B in the same cycle
        do_reset();
        arready = 1'b1;
        set_port(1, 1'b0, 32'h300, 0);
        s_req = 2'b10;
        #1 chk("s38_ok_r", s_addr_ok, 2'b10);
        tick();
        set_port(0, 1'b1, 32'h304, 32'h55);
        s_req = 2'b01;
        #1 chk("s38_ok_w", s_addr_ok, 2'b01);
        tick();
        s_req = 2'b00;
        awready = 1'b1;
        wready = 1'b1;
        tick();
        rvalid = 1'b1; rid = 1'b1; rdata = 32'h0bad_f00d;
        bvalid = 1'b1;
        #1 chk("s38_both", s_data_ok, 2'b11);
        chk("s38_rdata", s_rdata, 32'h0bad_f00d);
        tick();
        rvalid = 1'b0;
        bvalid = 1'b0;
        #1 chk("s38_quiet", s_data_ok, 2'b00);

        // asynchronous reset mid-transaction
        do_reset();
        set_port(0, 1'b0, 32'h500, 0);
        s_req = 2'b01;
        #1 chk("s39_ok", s_addr_ok, 2'b01);
        tick();
        s_req = 2'b00;
        #1 chk("s39_arv_pre", arvalid, 1);
        resetn = 1'b0;
        #1 chk("s39_arv_async", arvalid, 0);
        chk("s39_araddr_async", araddr, 0);
        tick();
        resetn = 1'b1;
        arready = 1'b1;
        s_req = 2'b01;
        #1 chk("s39_cnt_a", s_addr_ok, 2'b01);
        tick();
        #1 chk("s39_cnt_b", s_addr_ok, 2'b01);
        tick();
        #1 chk("s39_cnt_full", s_addr_ok, 2'b00);
        s_req = 2'b00;

        // randomised traffic
        do_reset();
        m_act = '0; m_wr = '0;
        aw_got = 1'b0; w_got = 1'b0;
        cur_wa = '0; cur_wd = '0;
        issued = 0; accepted = 0; cyc = 0;
        while ((accepted < NREQ || eq[0].size() > 0 || eq[1].size() > 0)
               && cyc < BUDGET) begin
            for (int p = 0; p < 2; p++) begin
                if (!m_act[p] && issued < NREQ && $urandom_range(3) != 0) begin
                    m_act[p]  = 1'b1;
                    m_wr[p]   = ($urandom_range(7) == 0);
                    m_addr[p] = $urandom & 32'hffff_fffc;
                    m_data[p] = $urandom;
                    issued++;
                end
                set_port(p, m_wr[p], m_addr[p], m_data[p]);
            end
            s_req   = m_act;
            arready = ($urandom_range(3) != 0);
            awready = ($urandom_range(1) != 0);
            wready  = ($urandom_range(1) != 0);
            rvalid  = 1'b0;
            if ((rq[0].size() > 0 || rq[1].size() > 0)
                && $urandom_range(3) != 0) begin
                int sel;
                sel = (rq[1].size() == 0) ? 0 :
                      (rq[0].size() == 0) ? 1 : int'($urandom_range(1));
                rvalid = 1'b1;
                rid    = 1'(sel);
                rdata  = rq[sel].pop_front();
            end
            bvalid = 1'b0;
            if (aw_got && w_got && $urandom_range(1) != 0) begin
                bvalid = 1'b1;
                aw_got = 1'b0;
                w_got  = 1'b0;
            end

            @(negedge clk);
            chk("rnd_onehot", $countones(s_addr_ok) <= 1, 1);
            if (arvalid && arready) rq[arid].push_back(araddr ^ K);
            if (awvalid && awready) begin
                chk("rnd_awaddr", awaddr, cur_wa);
                aw_got = 1'b1;
            end
            if (wvalid && wready) begin
                chk("rnd_wdata", wdata, cur_wd);
                w_got = 1'b1;
            end
            for (int p = 0; p < 2; p++) begin
                if (s_data_ok[p]) begin
                    chk($sformatf("rnd_q%0d_nonempty", p), eq[p].size() > 0, 1);
                    if (eq[p].size() > 0) begin
                        exp_t e;
                        e = eq[p].pop_front();
                        chk($sformatf("rnd_kind%0d", p),
                            e.wr ? bvalid : (rvalid && rid == 1'(p)), 1);
                        if (!e.wr)
                            chk($sformatf("rnd_rdata%0d", p), s_rdata, e.data);
                    end
                end
            end
            for (int p = 0; p < 2; p++) begin
                if (s_addr_ok[p]) begin
                    chk($sformatf("rnd_req%0d", p), m_act[p], 1);
                    eq[p].push_back('{m_wr[p], m_addr[p] ^ K});
                    if (m_wr[p]) begin
                        cur_wa = m_addr[p];
                        cur_wd = m_data[p];
                    end
                    m_act[p] = 1'b0;
                    accepted++;
                end
            end
            tick();
            cyc++;
        end
        chk("rnd_accepted", accepted, NREQ);
        chk("rnd_q0_drained", eq[0].size(), 0);
        chk("rnd_q1_drained", eq[1].size(), 0);
        chk("rnd_in_budget", cyc < BUDGET, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
